command_encoder: RTL
====================

COMMAND_ENCODER -- requirements
Module: command_encoder

Interface
REQ-001 The block SHALL have parameter ACK_TIMEOUT, default 16, setting the maximum number of clock cycles to wait for tx_busy to rise after a trans_en pulse.
REQ-002 The block SHALL have port clock, input, 1 bit: the single system clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port cmd_valid, input, 1 bit: request to send one command.
REQ-005 The block SHALL have port opcode, input, 8 bits: command opcode, sampled when the command is accepted.
REQ-006 The block SHALL have port command, input, 32 bits: command payload, sampled when the command is accepted.
REQ-007 The block SHALL have port cmd_ready, output, 1 bit: high only in IDLE.
REQ-008 The block SHALL have port tx_busy, input, 1 bit: UART transmitter busy flag.
REQ-009 The block SHALL have port trans_en, output, 1 bit: one-cycle strobe telling the UART to load data_out.
REQ-010 The block SHALL have port data_out, output, 8 bits: byte presented to the UART.
REQ-011 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-012 The block SHALL have port cmd_sent, output, 1 bit: one-cycle pulse when the final byte has fully drained.
REQ-013 The block SHALL have port tx_error, output, 1 bit: one-cycle pulse when an ACK_TIMEOUT expiry aborts a command.

Function
REQ-014 The block SHALL serialize commands into the byte stream that command_decoder consumes.
REQ-015 If opcode[7]=0 (short command), the block SHALL send exactly 1 byte: the opcode.
REQ-016 If opcode[7]=1 (long command), the block SHALL send exactly 5 bytes: the opcode, then command[7:0], command[15:8], command[23:16], command[31:24].
REQ-017 The block SHALL accept a command in the cycle cmd_valid=1 and cmd_ready=1, latching opcode and command into internal registers; later changes to the inputs SHALL NOT affect the frame being sent.
REQ-018 The block SHALL ignore cmd_valid while cmd_ready=0; such a command is not queued.
REQ-019 The block SHALL implement states IDLE, ISSUE, WAIT_ACK, WAIT_DRAIN, NEXT.
REQ-020 IDLE: on acceptance, go to ISSUE.
REQ-021 ISSUE: assert trans_en for exactly one cycle with data_out holding the current byte, clear the timeout counter, then go to WAIT_ACK.
REQ-022 WAIT_ACK: go to WAIT_DRAIN when tx_busy=1; if ACK_TIMEOUT cycles pass without tx_busy=1, pulse tx_error, do not pulse cmd_sent, and return to IDLE.
REQ-023 WAIT_DRAIN: go to NEXT when tx_busy=0.
REQ-024 NEXT: if the byte count is exhausted, pulse cmd_sent and go to IDLE; otherwise shift the payload register right by 8 bits, increment the 3-bit byte counter, and go to ISSUE.
REQ-025 data_out SHALL be stable from the trans_en cycle through the end of WAIT_DRAIN for that byte.
REQ-026 If tx_busy is already 1 on entry to ISSUE, ISSUE SHALL stall with trans_en=0 until tx_busy=0, then issue the byte.
REQ-027 The minimum gap between consecutive trans_en pulses SHALL be 3 cycles (ISSUE -> WAIT_ACK -> WAIT_DRAIN -> NEXT -> ISSUE).
REQ-028 cmd_ready SHALL return high in the cycle after the cmd_sent or tx_error pulse; back-to-back commands SHALL be accepted in that cycle.
REQ-029 cmd_sent and tx_error SHALL never be asserted in the same cycle.
REQ-030 The byte counter SHALL never exceed 4; it SHALL not wrap.

Reset
REQ-031 While reset_n=0, the block SHALL hold state=IDLE, cmd_ready=1, busy=0, trans_en=0, data_out=8'h00, cmd_sent=0, tx_error=0, and counters and payload register at 0.
REQ-032 Asserting reset_n mid-frame SHALL abort the frame immediately and asynchronously, with no further trans_en pulses; the remaining bytes are discarded.
REQ-033 After reset_n deasserts, the block SHALL be able to accept a command on the first rising edge.

Verification
REQ-034 Short command: opcode=8'h02, command=32'hDEADBEEF, UART model with 10-cycle busy -> exactly 1 trans_en pulse with data_out=8'h02, then 1 cmd_sent pulse.
REQ-035 Long command: opcode=8'hC0, command=32'h12345678 -> trans_en pulses carrying 8'hC0, 8'h78, 8'h56, 8'h34, 8'h12 in that order, then 1 cmd_sent pulse; feeding the same stream into command_decoder yields opcode=8'hC0, command=32'h12345678.
REQ-036 Input change after accept: accept opcode=8'h81; change the opcode and command inputs in the next cycle -> the transmitted bytes match the values latched at acceptance, and cmd_valid is ignored while busy=1.
REQ-037 Timeout: tx_busy held at 0 -> tx_error pulses exactly 16 cycles after the first trans_en; no cmd_sent pulse; cmd_ready=1 on the following cycle.
REQ-038 Reset mid-frame: assert reset_n=0 after the 2nd byte of a long command -> trans_en=0 immediately, no further bytes; a new short command after release sends 1 byte correctly.
REQ-039 Back-to-back: two long commands, with cmd_valid held high -> 10 bytes sent, 2 cmd_sent pulses, and the second command accepted in the cycle after the first cmd_sent.

Source files
------------

// File: rtl/command_encoder.sv
// command_encoder
//   Serializes one command into the byte stream a UART transmitter sends.
//   Short commands (opcode[7]=0) are one byte: the opcode.
//   Long commands (opcode[7]=1) are five bytes: opcode, then the command
//   payload least-significant byte first.
//
// Ports
//   clock      in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   cmd_valid  in   request to send one command
//   opcode     in   [7:0] opcode, latched on acceptance
//   command    in   [31:0] payload, latched on acceptance
//   cmd_ready  out  high only in IDLE
//   tx_busy    in   UART transmitter busy flag
//   trans_en   out  one-cycle strobe: UART loads data_out
//   data_out   out  [7:0] byte presented to the UART
//   busy       out  high whenever not IDLE
//   cmd_sent   out  one-cycle pulse once the final byte has drained
//   tx_error   out  one-cycle pulse when the ACK timeout aborts a command
//   dbg_state  out  [2:0] current FSM state encoding
//
// Handshake: a command is accepted on a rising edge where cmd_valid=1 and
// cmd_ready=1. cmd_valid seen while cmd_ready=0 is dropped, not queued.

module command_encoder #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        cmd_valid,
    input  logic [7:0]  opcode,
    input  logic [31:0] command,
    output logic        cmd_ready,
    input  logic        tx_busy,
    output logic        trans_en,
    output logic [7:0]  data_out,
    output logic        busy,
    output logic        cmd_sent,
    output logic        tx_error,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ISSUE      = 3'd1,
        ST_WAIT_ACK   = 3'd2,
        ST_WAIT_DRAIN = 3'd3,
        ST_NEXT       = 3'd4
    } state_e;

    localparam int              TW      = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0]   TO_LAST = TW'(ACK_TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [39:0]     payload_q, payload_d;   // {command, opcode}; byte 0 is on the wire
    logic            long_q, long_d;
    logic [2:0]      byte_cnt_q, byte_cnt_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
    logic [2:0]      last_idx;

    // Index of the final byte of the frame being sent.
    assign last_idx = long_q ? 3'd4 : 3'd0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            payload_q  <= '0;
            long_q     <= 1'b0;
            byte_cnt_q <= '0;
            to_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            payload_q  <= payload_d;
            long_q     <= long_d;
            byte_cnt_q <= byte_cnt_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        payload_d  = payload_q;
        long_d     = long_q;
        byte_cnt_d = byte_cnt_q;
        to_cnt_d   = to_cnt_q;
        trans_en   = 1'b0;
        cmd_sent   = 1'b0;
        tx_error   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    payload_d  = {command, opcode};
                    long_d     = opcode[7];
                    byte_cnt_d = '0;
                    to_cnt_d   = '0;
                    state_d    = ST_ISSUE;
                end
            end

            // Hold off while the UART is still busy with an earlier byte.
            ST_ISSUE: begin
                if (!tx_busy) begin
                    trans_en = 1'b1;
                    to_cnt_d = '0;
                    state_d  = ST_WAIT_ACK;
                end
            end

            // The last waiting cycle is the one where to_cnt_q reaches
            // ACK_TIMEOUT-1, so the error lands ACK_TIMEOUT cycles after trans_en.
            ST_WAIT_ACK: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DRAIN;
                end else if (to_cnt_q == TO_LAST) begin
                    tx_error = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end

            ST_WAIT_DRAIN: begin
                if (!tx_busy) begin
                    state_d = ST_NEXT;
                end
            end

            ST_NEXT: begin
                if (byte_cnt_q == last_idx) begin
                    cmd_sent = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    payload_d  = payload_q >> 8;
                    byte_cnt_d = byte_cnt_q + 3'd1;
                    state_d    = ST_ISSUE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The payload only shifts in NEXT, so data_out holds from the strobe
    // through the end of the drain wait.
    assign data_out  = payload_q[7:0];
    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;

endmodule
